ex_mem_branch_stage: RTL and testbench

- EX/MEM pipeline stage directly downstream of the 64-bit ALU in the LEGv8 datapath.
- Registers ALUResult/Zero together with the MEM/WB control and data fields.
- Resolves B/CBZ/CBNZ, computes the branch target, and drives the PC redirect to fetch.
- After a taken branch, squashes the wrong-path instructions still arriving from EX.

---
 rtl/ex_mem_branch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_ex_mem_branch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_branch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_branch_stage
// Brief    : LEGv8 EX/MEM pipeline register with B/CBZ/CBNZ resolution,
//            PC redirect and a wrong-path squash window after taken branches.
//            Optional statistics counters enabled by EXMEM_BRANCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_branch_stage #(
    parameter int SQUASH_DEPTH = 2,
    parameter int CNT_W        = 32
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] ALUResult,
    input  logic        Zero,
    input  logic [63:0] pc_in,
    input  logic [63:0] branch_offset,
    input  logic        uncond_branch,
    input  logic        cbz,
    input  logic        cbnz,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_to_reg,
    input  logic [4:0]  write_reg,
    input  logic [63:0] store_data,
    output logic        out_valid,
    output logic [63:0] alu_result_q,
    output logic [63:0] store_data_q,
    output logic [4:0]  write_reg_q,
    output logic        mem_read_q,
    output logic        mem_write_q,
    output logic        reg_write_q,
    output logic        mem_to_reg_q,
    output logic        branch_taken,
    output logic [63:0] branch_target,
    output logic        squashing
`ifdef EXMEM_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_squashed,
    output logic [CNT_W-1:0] stat_retired
`endif
);

    localparam int c_sq_w = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);
    localparam logic [c_sq_w-1:0] c_sq_load = c_sq_w'(SQUASH_DEPTH);
    localparam int c_unused_cnt_w = CNT_W;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_sq_w-1:0] r_sq_cnt;
    logic [c_sq_w-1:0] w_sq_cnt_nxt;

    logic        r_valid;
    logic [63:0] r_alu_result;
    logic [63:0] r_store_data;
    logic [4:0]  r_write_reg;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_taken;
    logic [63:0] r_target;

    logic        w_accept;
    logic        w_take;
    logic [63:0] w_target;

    // Branches are only evaluated in RUN, so a wrong-path branch cannot retrigger.
    assign w_accept = in_valid & (r_state == ST_RUN);
    assign w_take   = w_accept & (uncond_branch | (cbz & Zero) | (cbnz & ~Zero));
    assign w_target = pc_in + (branch_offset << 2);

    always_comb begin
        w_state_nxt  = r_state;
        w_sq_cnt_nxt = r_sq_cnt;
        if (flush) begin
            w_state_nxt  = ST_RUN;
            w_sq_cnt_nxt = '0;
        end else if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_take && (SQUASH_DEPTH > 0)) begin
                        w_state_nxt  = ST_SQUASH;
                        w_sq_cnt_nxt = c_sq_load;
                    end
                end
                ST_SQUASH: begin
                    if (r_sq_cnt <= c_sq_w'(1)) begin
                        w_state_nxt  = ST_RUN;
                        w_sq_cnt_nxt = '0;
                    end else begin
                        w_sq_cnt_nxt = r_sq_cnt - c_sq_w'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_sq_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_RUN;
            r_sq_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sq_cnt <= w_sq_cnt_nxt;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_write_reg  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
        end else if (flush) begin
            // Data fields are left as-is; nothing downstream looks at them.
            r_valid      <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_taken      <= 1'b0;
        end else if (!stall) begin
            r_valid      <= w_accept;
            r_alu_result <= ALUResult;
            r_store_data <= store_data;
            r_write_reg  <= write_reg;
            r_mem_read   <= mem_read;
            r_mem_write  <= mem_write;
            r_reg_write  <= reg_write;
            r_mem_to_reg <= mem_to_reg;
            r_taken      <= w_take;
            r_target     <= w_target;
        end
    end

    assign out_valid     = r_valid;
    assign alu_result_q  = r_alu_result;
    assign store_data_q  = r_store_data;
    assign write_reg_q   = r_write_reg;
    assign mem_read_q    = r_mem_read   & r_valid;
    assign mem_write_q   = r_mem_write  & r_valid;
    assign reg_write_q   = r_reg_write  & r_valid;
    assign mem_to_reg_q  = r_mem_to_reg & r_valid;
    assign branch_taken  = r_taken;
    assign branch_target = r_target;
    assign squashing     = (r_sq_cnt != '0);

`ifdef EXMEM_BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_taken;
    logic [CNT_W-1:0] r_stat_squashed;
    logic [CNT_W-1:0] r_stat_retired;
    logic             w_squash_evt;

    assign w_squash_evt = in_valid & (r_sq_cnt != '0);

    // Saturating event counters; they only advance on edges that commit state.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_stat_taken    <= '0;
            r_stat_squashed <= '0;
            r_stat_retired  <= '0;
        end else if (!flush && !stall) begin
            if (w_take && (r_stat_taken != '1)) begin
                r_stat_taken <= r_stat_taken + 1'b1;
            end
            if (w_squash_evt && (r_stat_squashed != '1)) begin
                r_stat_squashed <= r_stat_squashed + 1'b1;
            end
            if (w_accept && (r_stat_retired != '1)) begin
                r_stat_retired <= r_stat_retired + 1'b1;
            end
        end
    end

    assign stat_taken    = r_stat_taken;
    assign stat_squashed = r_stat_squashed;
    assign stat_retired  = r_stat_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_branch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_branch_stage
// Brief    : Scoreboard bench for ex_mem_branch_stage: directed scenarios then
//            random traffic against a behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_branch_stage;

    localparam int c_depth  = 2;
    localparam int c_cnt_w  = 4;
    localparam int c_sat    = (1 << c_cnt_w) - 1;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        in_valid, stall, flush, Zero, uncond_branch, cbz, cbnz;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [63:0] ALUResult, pc_in, branch_offset, store_data;
    logic [4:0]  write_reg;
    logic        out_valid, mem_read_q, mem_write_q, reg_write_q, mem_to_reg_q;
    logic        branch_taken, squashing;
    logic [63:0] alu_result_q, store_data_q, branch_target;
    logic [4:0]  write_reg_q;
`ifdef EXMEM_BRANCH_STATS_EN
    logic [c_cnt_w-1:0] stat_taken, stat_squashed, stat_retired;
`endif

    ex_mem_branch_stage #(.SQUASH_DEPTH(c_depth), .CNT_W(c_cnt_w)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALUResult(ALUResult), .Zero(Zero), .pc_in(pc_in), .branch_offset(branch_offset),
        .uncond_branch(uncond_branch), .cbz(cbz), .cbnz(cbnz),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .write_reg(write_reg), .store_data(store_data),
        .out_valid(out_valid), .alu_result_q(alu_result_q), .store_data_q(store_data_q),
        .write_reg_q(write_reg_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
        .reg_write_q(reg_write_q), .mem_to_reg_q(mem_to_reg_q),
        .branch_taken(branch_taken), .branch_target(branch_target), .squashing(squashing)
`ifdef EXMEM_BRANCH_STATS_EN
        , .stat_taken(stat_taken), .stat_squashed(stat_squashed), .stat_retired(stat_retired)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        valid;
        logic [63:0] alu;
        logic [63:0] sd;
        logic [4:0]  wr;
        logic        mr, mw, rw, mtr;
        logic        bt;
        logic [63:0] tgt;
        logic        sq;
        logic        data_known;
        int          st_t, st_s, st_r;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   m_cnt;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        in_valid = 0; stall = 0; flush = 0; Zero = 0;
        uncond_branch = 0; cbz = 0; cbnz = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
        ALUResult = '0; pc_in = '0; branch_offset = '0; store_data = '0; write_reg = '0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= c_sat) ? c_sat : v + 1;
    endfunction

    // Model the effect of the coming rising edge, queue it, then advance to the next negedge.
    task automatic issue();
        logic acc, tk;
        if (RESET) begin
            m = '{default: '0};
            m.data_known = 1'b1;
            m_cnt = 0;
        end else if (flush) begin
            m.valid = 0; m.mr = 0; m.mw = 0; m.rw = 0; m.mtr = 0; m.bt = 0;
            m.data_known = 0;
            m_cnt = 0;
        end else if (!stall) begin
            acc = in_valid && (m_cnt == 0);
            tk  = acc && (uncond_branch || (cbz && Zero) || (cbnz && !Zero));
            if (tk) m.st_t = sat_inc(m.st_t);
            if (in_valid && m_cnt != 0) m.st_s = sat_inc(m.st_s);
            if (acc) m.st_r = sat_inc(m.st_r);
            m.valid = acc;
            m.alu = ALUResult; m.sd = store_data; m.wr = write_reg;
            m.mr = acc & mem_read; m.mw = acc & mem_write;
            m.rw = acc & reg_write; m.mtr = acc & mem_to_reg;
            m.bt = tk;
            m.tgt = pc_in + branch_offset * 64'd4;
            m.data_known = 1;
            if (tk) m_cnt = c_depth;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
        m.sq = (m_cnt != 0);
        q.push_back(m);
        @(negedge CLOCK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_valid", 64'(out_valid), 64'(e.valid));
                chk("mem_read_q", 64'(mem_read_q), 64'(e.mr));
                chk("mem_write_q", 64'(mem_write_q), 64'(e.mw));
                chk("reg_write_q", 64'(reg_write_q), 64'(e.rw));
                chk("mem_to_reg_q", 64'(mem_to_reg_q), 64'(e.mtr));
                chk("branch_taken", 64'(branch_taken), 64'(e.bt));
                chk("squashing", 64'(squashing), 64'(e.sq));
                if (e.data_known) begin
                    chk("alu_result_q", alu_result_q, e.alu);
                    chk("store_data_q", store_data_q, e.sd);
                    chk("write_reg_q", 64'(write_reg_q), 64'(e.wr));
                    chk("branch_target", branch_target, e.tgt);
                end
`ifdef EXMEM_BRANCH_STATS_EN
                chk("stat_taken", 64'(stat_taken), 64'(e.st_t));
                chk("stat_squashed", 64'(stat_squashed), 64'(e.st_s));
                chk("stat_retired", 64'(stat_retired), 64'(e.st_r));
`endif
            end
        end
    end

    initial begin : driver
        int wait_cycles;
        m = '{default: '0};
        m_cnt = 0;
        clear_in();
        RESET = 1;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_branch_taken", 64'(branch_taken), 64'd0);
        chk("reset_squashing", 64'(squashing), 64'd0);
        chk("reset_alu_result_q", alu_result_q, 64'd0);
        @(negedge CLOCK);
        issue();
        RESET = 0;

        // ALU passthrough
        clear_in(); in_valid = 1; ALUResult = 64'h0000_0000_DEAD_BEEF; reg_write = 1; write_reg = 5'd9;
        issue();
        // CBZ taken, two squashed stores, third accepted
        clear_in(); in_valid = 1; cbz = 1; Zero = 1; pc_in = 64'h100; branch_offset = -64'sd4;
        issue();
        for (int i = 0; i < 3; i++) begin
            clear_in(); in_valid = 1; mem_write = 1; ALUResult = 64'(i + 100);
            issue();
        end
        // CBNZ with Zero set is not taken
        clear_in(); in_valid = 1; cbnz = 1; Zero = 1;
        issue();
        // Unconditional branch whose target wraps to 0x4
        clear_in(); in_valid = 1; uncond_branch = 1;
        pc_in = 64'hFFFF_FFFF_FFFF_FFFC; branch_offset = 64'd2;
        issue();
        repeat (3) begin
            clear_in(); in_valid = 1; stall = 1; mem_write = 1;
            issue();
        end
        clear_in(); in_valid = 1; stall = 1; flush = 1; uncond_branch = 1;
        issue();
        clear_in(); in_valid = 1; reg_write = 1; write_reg = 5'd3; ALUResult = 64'h55;
        issue();
        // Asynchronous reset in the middle of a squash window
        clear_in(); in_valid = 1; uncond_branch = 1; pc_in = 64'h2000; branch_offset = 64'd8;
        issue();
        RESET = 1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_branch_taken", 64'(branch_taken), 64'd0);
        chk("async_rst_squashing", 64'(squashing), 64'd0);
        chk("async_rst_branch_target", branch_target, 64'd0);
        issue();
        RESET = 0;

        for (int n = 0; n < 800; n++) begin
            in_valid      = ($urandom_range(0, 9) < 8);
            stall         = ($urandom_range(0, 6) == 0);
            flush         = ($urandom_range(0, 24) == 0);
            RESET         = ($urandom_range(0, 99) == 0);
            uncond_branch = ($urandom_range(0, 7) == 0);
            cbz           = ($urandom_range(0, 5) == 0);
            cbnz          = ($urandom_range(0, 5) == 0);
            Zero          = 1'($urandom_range(0, 1));
            mem_read      = 1'($urandom_range(0, 1));
            mem_write     = 1'($urandom_range(0, 1));
            reg_write     = 1'($urandom_range(0, 1));
            mem_to_reg    = 1'($urandom_range(0, 1));
            write_reg     = 5'($urandom_range(0, 31));
            ALUResult     = {$urandom(), $urandom()};
            store_data    = {$urandom(), $urandom()};
            pc_in         = {$urandom(), $urandom()};
            branch_offset = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()}
                                                        : 64'($signed(12'($urandom())));
            issue();
        end
        RESET = 0;
        clear_in();
        issue();

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge CLOCK);
            #2;
            wait_cycles++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
